ct_vfalu_pipe7_wb_sched: RTL and testbench

// Writeback-slot scheduler for VFALU pipe7. Reserves the single ex3 result port at

---
 rtl/ct_vfalu_pipe7_wb_sched.sv | 128 ++++++++++++
 tb/tb_ct_vfalu_pipe7_wb_sched.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/ct_vfalu_pipe7_wb_sched.sv
// rtl/ct_vfalu_pipe7_wb_sched.sv - VFALU pipe7 ex3 writeback-slot scheduler
module ct_vfalu_pipe7_wb_sched #(
  parameter int FADD_LAT  = 3,
  parameter int FCNVT_LAT = 3,
  parameter int FSPU_LAT  = 1,
  parameter int MAX_LAT   = 4
) (
  input  logic       forever_cpuclk,
  input  logic       cpurst,
  input  logic       fadd_req,
  input  logic       fcnvt_req,
  input  logic       fspu_req,
  input  logic       fadd_req_ereg,
  input  logic       fcnvt_req_ereg,
  input  logic       fspu_req_ereg,
  output logic       fadd_gnt,
  output logic       fcnvt_gnt,
  output logic       fspu_gnt,
  input  logic       pipe_stall,
  input  logic       pipe_flush,
  input  logic       fadd_forward_r_vld,
  input  logic       fcnvt_forward_r_vld,
  input  logic       fspu_forward_r_vld,
  output logic [2:0] pipex_wb_sel,
  output logic       pipex_wb_vld,
  output logic       pipex_wb_ereg_vld,
  output logic       wb_conflict_err
);

  if (FADD_LAT < 1 || FADD_LAT > MAX_LAT || FCNVT_LAT < 1 || FCNVT_LAT > MAX_LAT ||
      FSPU_LAT < 1 || FSPU_LAT > MAX_LAT) begin : g_bad_lat
    $error("ct_vfalu_pipe7_wb_sched: unit latency outside 1..MAX_LAT");
  end

  localparam int SW = $clog2(MAX_LAT + 1);
  localparam int CW = $clog2(MAX_LAT + 2);
  localparam int LAT [3] = '{FADD_LAT, FCNVT_LAT, FSPU_LAT};

  // owner encoding: 0 fadd, 1 fcnvt, 2 fspu
  typedef struct packed {
    logic       vld;
    logic [1:0] owner;
    logic       ereg;
  } slot_t;

  slot_t          slot_q [0:MAX_LAT];
  slot_t          slot_d [0:MAX_LAT];
  logic [1:0]     rr_q, rr_d;
  logic [CW-1:0]  sup_q, sup_d;
  logic           err_q, err_d;

  logic [2:0]     req, ereg, elig, gnt, contended;
  logic [2:0]     strobe;
  logic           mismatch;

  always_comb begin
    req       = {fspu_req, fcnvt_req, fadd_req};
    ereg      = {fspu_req_ereg, fcnvt_req_ereg, fadd_req_ereg};
    elig      = '0;
    gnt       = '0;
    contended = '0;
    rr_d      = rr_q;
    for (int u = 0; u < 3; u++) begin
      elig[u] = req[u] & ~pipe_stall & ~pipe_flush & ~slot_q[SW'(LAT[u])].vld;
    end
    // Round-robin among units that target the same writeback slot
    for (int u = 0; u < 3; u++) begin
      gnt[u] = elig[u];
      for (int v = 0; v < 3; v++) begin
        if (v != u && elig[v] && LAT[v] == LAT[u]) begin
          contended[u] = 1'b1;
          if (((v + 3 - int'(rr_q)) % 3) < ((u + 3 - int'(rr_q)) % 3)) gnt[u] = 1'b0;
        end
      end
    end
    for (int u = 0; u < 3; u++) begin
      if (gnt[u] && contended[u]) rr_d = 2'((u + 1) % 3);
    end
  end

  assign fadd_gnt  = gnt[0];
  assign fcnvt_gnt = gnt[1];
  assign fspu_gnt  = gnt[2];

  always_comb begin
    for (int k = 0; k <= MAX_LAT; k++) slot_d[SW'(k)] = slot_q[SW'(k)];
    if (pipe_flush) begin
      for (int k = 0; k <= MAX_LAT; k++) slot_d[SW'(k)] = '0;
    end else if (!pipe_stall) begin
      for (int k = 0; k < MAX_LAT; k++) slot_d[SW'(k)] = slot_q[SW'(k + 1)];
      slot_d[SW'(MAX_LAT)] = '0;
      for (int u = 0; u < 3; u++) begin
        if (gnt[u]) slot_d[SW'(LAT[u] - 1)] = '{vld: 1'b1, owner: 2'(u), ereg: ereg[u]};
      end
    end
  end

  assign pipex_wb_sel      = slot_q[0].vld ? (3'b100 >> slot_q[0].owner) : 3'b000;
  assign pipex_wb_vld      = slot_q[0].vld;
  assign pipex_wb_ereg_vld = slot_q[0].vld & slot_q[0].ereg;
  assign wb_conflict_err   = err_q;

  // Strobes for writebacks dropped by flush/reset may still arrive; ignore them for a while
  assign strobe   = {fadd_forward_r_vld, fcnvt_forward_r_vld, fspu_forward_r_vld};
  assign mismatch = (sup_q == '0) && (strobe != pipex_wb_sel);
  assign err_d    = err_q | mismatch;

  always_comb begin
    if (pipe_flush)       sup_d = CW'(MAX_LAT + 1);
    else if (sup_q != '0) sup_d = sup_q - 1'b1;
    else                  sup_d = '0;
  end

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      for (int k = 0; k <= MAX_LAT; k++) slot_q[SW'(k)] <= '0;
      rr_q  <= 2'd0;
      sup_q <= CW'(MAX_LAT + 1);
      err_q <= 1'b0;
    end else begin
      for (int k = 0; k <= MAX_LAT; k++) slot_q[SW'(k)] <= slot_d[SW'(k)];
      rr_q  <= rr_d;
      sup_q <= sup_d;
      err_q <= err_d;
    end
  end

endmodule

// File: tb/tb_ct_vfalu_pipe7_wb_sched.sv
// tb/tb_ct_vfalu_pipe7_wb_sched.sv - directed self-checking bench for the pipe7 wb scheduler
module tb_ct_vfalu_pipe7_wb_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       fadd_req, fcnvt_req, fspu_req;
  logic       fadd_req_ereg, fcnvt_req_ereg, fspu_req_ereg;
  logic       fadd_gnt, fcnvt_gnt, fspu_gnt;
  logic       stall, flush;
  logic       fadd_fv, fcnvt_fv, fspu_fv;
  logic [2:0] wb_sel;
  logic       wb_vld, wb_ereg_vld, err;
  logic       loop_en;
  logic [2:0] m_fv;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  // Well-behaved units strobe exactly when they own the port
  assign fadd_fv  = loop_en ? wb_sel[2] : m_fv[2];
  assign fcnvt_fv = loop_en ? wb_sel[1] : m_fv[1];
  assign fspu_fv  = loop_en ? wb_sel[0] : m_fv[0];

  ct_vfalu_pipe7_wb_sched dut (
    .forever_cpuclk      (clk),
    .cpurst              (rst),
    .fadd_req            (fadd_req),
    .fcnvt_req           (fcnvt_req),
    .fspu_req            (fspu_req),
    .fadd_req_ereg       (fadd_req_ereg),
    .fcnvt_req_ereg      (fcnvt_req_ereg),
    .fspu_req_ereg       (fspu_req_ereg),
    .fadd_gnt            (fadd_gnt),
    .fcnvt_gnt           (fcnvt_gnt),
    .fspu_gnt            (fspu_gnt),
    .pipe_stall          (stall),
    .pipe_flush          (flush),
    .fadd_forward_r_vld  (fadd_fv),
    .fcnvt_forward_r_vld (fcnvt_fv),
    .fspu_forward_r_vld  (fspu_fv),
    .pipex_wb_sel        (wb_sel),
    .pipex_wb_vld        (wb_vld),
    .pipex_wb_ereg_vld   (wb_ereg_vld),
    .wb_conflict_err     (err)
  );

  task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_gnt(input string tag, input logic [2:0] exp);
    chk(tag, {2'b00, fadd_gnt, fcnvt_gnt, fspu_gnt}, {2'b00, exp});
  endtask

  // {sel, vld, ereg_vld}; vld follows sel
  task automatic chk_out(input string tag, input logic [2:0] sel, input logic ereg);
    chk(tag, {wb_sel, wb_vld, wb_ereg_vld}, {sel, |sel, ereg});
  endtask

  task automatic chk_err(input string tag, input logic exp);
    chk(tag, {4'b0000, err}, {4'b0000, exp});
  endtask

  task automatic nc();
    @(negedge clk);
  endtask

  task automatic clear();
    fadd_req = 0; fcnvt_req = 0; fspu_req = 0;
    fadd_req_ereg = 0; fcnvt_req_ereg = 0; fspu_req_ereg = 0;
    stall = 0; flush = 0;
  endtask

  initial begin
    clear();
    loop_en = 1; m_fv = 3'b000; rst = 1;
    nc(); nc();
    rst = 0; #1;
    chk_out("reset_out", 3'b000, 0);
    chk_err("reset_err", 0);
    chk_gnt("reset_gnt", 3'b000);
    repeat (7) nc();

    // fspu L=1 with ereg
    nc(); fspu_req = 1; fspu_req_ereg = 1; #1;
    chk_gnt("A_t0_gnt", 3'b001); chk_out("A_t0_out", 3'b000, 0);
    nc(); clear(); #1; chk_out("A_t1_out", 3'b001, 1);
    nc(); #1; chk_out("A_t2_out", 3'b000, 0);

    // fadd vs fcnvt contention, rr starts at fadd
    nc(); fadd_req = 1; fcnvt_req = 1; #1; chk_gnt("B_t0_gnt", 3'b100);
    nc(); #1; chk_gnt("B_t1_gnt", 3'b010);
    nc(); clear(); #1; chk_out("B_t2_out", 3'b000, 0);
    nc(); #1; chk_out("B_t3_out", 3'b100, 0);
    nc(); #1; chk_out("B_t4_out", 3'b010, 0);
    nc(); #1; chk_out("B_t5_out", 3'b000, 0);

    // fspu blocked by an fadd reservation already sitting in slot 1
    nc(); fadd_req = 1; #1; chk_gnt("K_t0_gnt", 3'b100);
    nc(); clear();
    nc(); fspu_req = 1; #1; chk_gnt("K_t2_gnt", 3'b000);
    nc(); #1; chk_gnt("K_t3_gnt", 3'b001); chk_out("K_t3_out", 3'b100, 0);
    nc(); clear(); #1; chk_out("K_t4_out", 3'b001, 0);
    nc(); #1; chk_out("K_t5_out", 3'b000, 0);

    // different latencies grant together
    nc(); fadd_req = 1; fspu_req = 1; #1; chk_gnt("C_t0_gnt", 3'b101);
    nc(); clear(); #1; chk_out("C_t1_out", 3'b001, 0);
    nc(); nc(); #1; chk_out("C_t3_out", 3'b100, 0);
    nc(); #1; chk_out("C_t4_out", 3'b000, 0);

    // stall in flight and while owning the port
    nc(); fadd_req = 1; #1; chk_gnt("S_t0_gnt", 3'b100);
    nc(); stall = 1; #1; chk_gnt("S_t1_gnt", 3'b000);
    nc(); #1; chk_gnt("S_t2_gnt", 3'b000);
    nc(); clear(); #1; chk_out("S_t3_out", 3'b000, 0);
    nc(); #1; chk_out("S_t4_out", 3'b000, 0);
    nc(); stall = 1; #1; chk_out("S_t5_out", 3'b100, 0);
    nc(); #1; chk_out("S_t6_out", 3'b100, 0);
    nc(); #1; chk_out("S_t7_out", 3'b100, 0);
    nc(); stall = 0; #1; chk_out("S_t8_out", 3'b100, 0);
    nc(); #1; chk_out("S_t9_out", 3'b000, 0);

    // flush while slot 0 owns the port; flush beats stall and blocks grants
    nc(); fspu_req = 1; #1; chk_gnt("F_t0_gnt", 3'b001);
    nc(); clear(); flush = 1; stall = 1; fadd_req = 1; #1;
    chk_out("F_t1_out", 3'b001, 0); chk_gnt("F_t1_gnt", 3'b000);
    nc(); clear(); #1; chk_out("F_t2_out", 3'b000, 0);

    // flush drops a pending fadd; its late strobe is suppressed
    nc(); fadd_req = 1; #1; chk_gnt("G_t0_gnt", 3'b100);
    nc(); clear(); flush = 1; #1; chk_out("G_t1_out", 3'b000, 0);
    nc(); clear(); #1; chk_out("G_t2_out", 3'b000, 0);
    nc(); loop_en = 0; m_fv = 3'b100; #1; chk_out("G_t3_out", 3'b000, 0); chk_err("G_t3_err", 0);
    nc(); m_fv = 3'b000; loop_en = 1; #1; chk_err("G_t4_err", 0);
    repeat (6) nc();

    // unsolicited fcnvt strobe sets a sticky error
    nc(); loop_en = 0; m_fv = 3'b010; #1; chk_err("E_t0_err", 0);
    nc(); m_fv = 3'b000; loop_en = 1; #1; chk_err("E_t1_err", 1);
    nc(); nc(); #1; chk_err("E_t3_err", 1);

    // rr currently at fspu: fadd ranks ahead of fcnvt, rr moves to fcnvt
    nc(); fadd_req = 1; fcnvt_req = 1; #1; chk_gnt("R_t0_gnt", 3'b100);
    nc(); clear(); rst = 1;
    nc(); rst = 0; #1;
    chk_out("R_rst_out", 3'b000, 0); chk_err("R_rst_err", 0);
    nc(); fadd_req = 1; fcnvt_req = 1; #1; chk_gnt("R_rr_gnt", 3'b100);
    nc(); clear();
    nc(); nc(); #1; chk_out("R_t3_out", 3'b100, 0);
    nc(); #1; chk_out("R_t4_out", 3'b000, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
